// File: rtl/seg_pkg.sv
// Shared types and glyph table for the 7-segment readback path.
`timescale 1ns/1ps
package seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned PIN_W = SEG_W + 1;

  // Lit-high segment patterns, bit0 = a .. bit6 = g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  typedef struct packed {
    logic             invalid;
    logic             dp;
    logic [NIB_W-1:0] nibble;
  } seg_sym_t;

  localparam int unsigned SYM_W = $bits(seg_sym_t);

  // Map a lit-high segment pattern to its hex value; dp is left for the caller.
  function automatic seg_sym_t seg_decode(input logic [SEG_W-1:0] seg);
    seg_sym_t sym;
    sym = '0;
    case (seg)
      SEG_0:   sym.nibble = 4'h0;
      SEG_1:   sym.nibble = 4'h1;
      SEG_2:   sym.nibble = 4'h2;
      SEG_3:   sym.nibble = 4'h3;
      SEG_4:   sym.nibble = 4'h4;
      SEG_5:   sym.nibble = 4'h5;
      SEG_6:   sym.nibble = 4'h6;
      SEG_7:   sym.nibble = 4'h7;
      SEG_8:   sym.nibble = 4'h8;
      SEG_9:   sym.nibble = 4'h9;
      SEG_A:   sym.nibble = 4'hA;
      SEG_B:   sym.nibble = 4'hB;
      SEG_C:   sym.nibble = 4'hC;
      SEG_D:   sym.nibble = 4'hD;
      SEG_E:   sym.nibble = 4'hE;
      SEG_F:   sym.nibble = 4'hF;
      default: sym.invalid = 1'b1;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/seg_readback_if.sv
// Valid/ready read port carrying one decoded display symbol.
`timescale 1ns/1ps
interface seg_readback_if;
  import seg_pkg::*;

  logic             rd_valid;
  logic             rd_ready;
  logic [NIB_W-1:0] rd_nibble;
  logic             rd_dp;
  logic             rd_invalid;

  modport master (
    output rd_valid, rd_nibble, rd_dp, rd_invalid,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_nibble, rd_dp, rd_invalid,
    output rd_ready
  );
endinterface

// File: rtl/seg_fifo.sv
// Synchronous FIFO; a push into a full FIFO lands only when a pop frees a slot the same cycle.
`timescale 1ns/1ps
module seg_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign rdata     = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/seg_readback.sv
// Samples the chip's segment pins, debounces them and queues each new stable glyph as a hex symbol.
`timescale 1ns/1ps
module seg_readback
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [SEG_W-1:0]            seg_in,
  input  logic                        dp_in,
  input  logic                        clear_ovf,
  seg_readback_if.master              rd,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        ovf
);

  localparam int unsigned      CNT_W     = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [PIN_W-1:0] PIN_POL   = {PIN_W{ACTIVE_LOW}};
  localparam logic [PIN_W-1:0] PIN_BLANK = {1'b0, SEG_BLANK};

  logic [PIN_W-1:0] sync1;
  logic [PIN_W-1:0] sync2;
  logic [PIN_W-1:0] synced_c;
  logic [PIN_W-1:0] cand;
  logic [PIN_W-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic             drop_c;
  seg_sym_t         push_sym_c;
  seg_sym_t         head;
  logic             full;
  logic             empty;

  // Two-flop synchronizer; reset value is the unlit pin level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= PIN_POL;
      sync2 <= PIN_POL;
    end else begin
      sync1 <= {dp_in, seg_in};
      sync2 <= sync1;
    end
  end

  assign synced_c = sync2 ^ PIN_POL;

  // Stability filter: cnt counts repeats of cand, saturating once it is trusted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand <= PIN_BLANK;
      cnt  <= '0;
      last <= PIN_BLANK;
    end else begin
      if (synced_c != cand) begin
        cand <= synced_c;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept_c) last <= cand;
    end
  end

  // Blank glyphs only re-arm the filter so a digit repeated around a blank is queued twice
  always_comb begin
    accept_c      = (synced_c == cand) && (cnt == CNT_MAX) && (cand != last);
    push_c        = accept_c && (cand[SEG_W-1:0] != SEG_BLANK);
    push_sym_c    = seg_decode(cand[SEG_W-1:0]);
    push_sym_c.dp = cand[PIN_W-1];
  end

  assign pop_c  = rd.rd_valid && rd.rd_ready;
  assign drop_c = push_c && full && !pop_c;

  seg_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (push_sym_c),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop_c) begin
      ovf <= 1'b1;
    end else if (clear_ovf) begin
      ovf <= 1'b0;
    end
  end

  // Head fields read as zero while the FIFO is empty
  always_comb begin
    rd.rd_valid   = !empty;
    rd.rd_nibble  = '0;
    rd.rd_dp      = 1'b0;
    rd.rd_invalid = 1'b0;
    if (!empty) begin
      rd.rd_nibble  = head.nibble;
      rd.rd_dp      = head.dp;
      rd.rd_invalid = head.invalid;
    end
  end

endmodule

// File: tb/tb_seg_readback.sv
// Directed and random-stall bench for seg_readback against a run-length/queue model.
`timescale 1ns/1ps
module tb_seg_readback;

  localparam int STABLE = 4;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic       dp_in;
  logic       clear_ovf;
  logic [2:0] level;
  logic       ovf;

  seg_readback_if rif ();

  seg_readback #(
    .STABLE_CYCLES (STABLE),
    .FIFO_DEPTH    (DEPTH),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .seg_in    (seg_in),
    .dp_in     (dp_in),
    .clear_ovf (clear_ovf),
    .rd        (rif),
    .level     (level),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected symbol {invalid, dp, nibble} from a lit-high pin pattern
  function automatic logic [5:0] exp_sym(input logic [7:0] p);
    for (int i = 0; i < 16; i++)
      if (gl[i] == p[6:0]) return {1'b0, p[7], 4'(i)};
    return {1'b1, p[7], 4'h0};
  endfunction

  // Model: a lit-high pattern seen for STABLE+1 consecutive samples that differs
  // from the last accepted one is accepted; it reaches the queue two edges after
  // its qualifying sample (synchronizer delay).
  logic [5:0] mq [$];
  bit         m_ovf;
  logic [7:0] m_last, cur_p, h1_p, h2_p, s;
  int         cur_r, h1_r, h2_r;
  bit         acc, pop, push, drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_last = 8'h00;
      cur_p  = 8'h00; cur_r = 0;
      h1_p   = 8'h00; h1_r  = 0;
      h2_p   = 8'h00; h2_r  = 0;
    end else begin
      s    = {dp_in, seg_in} ^ 8'hFF;
      acc  = (h2_r == STABLE + 1) && (h2_p != m_last);
      pop  = (mq.size() > 0) && rif.rd_ready;
      push = acc && (h2_p[6:0] != 7'h00);
      drop = 1'b0;
      if (acc) m_last = h2_p;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(exp_sym(h2_p));
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      if (s == cur_p) begin
        if (cur_r < 1000) cur_r++;
      end else begin
        cur_p = s;
        cur_r = 1;
      end
      h2_p = h1_p; h2_r = h1_r;
      h1_p = cur_p; h1_r = cur_r;
    end
  end

  // Cycle-by-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("valid", 32'(rif.rd_valid), 32'(mq.size() > 0));
      check("level", 32'(level), 32'(mq.size()));
      check("ovf", 32'(ovf), 32'(m_ovf));
      if (mq.size() > 0)
        check("head", 32'({rif.rd_invalid, rif.rd_dp, rif.rd_nibble}), 32'(mq[0]));
    end
  end

  task automatic drive(input logic [6:0] lit, input logic dp_lit, input int cycles);
    seg_in = ~lit;
    dp_in  = ~dp_lit;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [5:0] exp);
    check({name, "_valid"}, 32'(rif.rd_valid), 32'd1);
    check(name, 32'({rif.rd_invalid, rif.rd_dp, rif.rd_nibble}), 32'(exp));
    rif.rd_ready = 1'b1;
    @(negedge clk);
    rif.rd_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    seg_in       = 7'h7F;
    dp_in        = 1'b1;
    clear_ovf    = 1'b0;
    rif.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rif.rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_nibble", 32'(rif.rd_nibble), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 1: glyph 3, dp pin high (unlit); seven edges to rd_valid
    seg_in = ~7'h4F;
    dp_in  = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("t1_lat6_valid", 32'(rif.rd_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_lat7_valid", 32'(rif.rd_valid), 32'd1);
    check("t1_nibble", 32'(rif.rd_nibble), 32'd3);
    check("t1_dp", 32'(rif.rd_dp), 32'd0);
    check("t1_invalid", 32'(rif.rd_invalid), 32'd0);
    @(negedge clk);
    pop_expect("t1_pop", 6'h03);
    check("t1_level_after", 32'(level), 32'd0);

    // 2: short glitch to 5 then back to 3 is ignored
    drive(gl[5], 1'b0, 3);
    drive(gl[3], 1'b0, 12);
    check("t2_level", 32'(level), 32'd0);

    // 3: 1, blank, 1 gives two entries; then a non-hex pattern
    drive(gl[1], 1'b0, 8);
    drive(7'h00, 1'b0, 8);
    drive(gl[1], 1'b0, 10);
    drive(7'h49, 1'b0, 10);
    check("t3_level", 32'(level), 32'd3);
    pop_expect("t3_e0", 6'h01);
    pop_expect("t3_e1", 6'h01);
    pop_expect("t3_inv", 6'h20);

    // 4: overflow with a stalled consumer, clear, then push+pop while full
    for (int i = 0; i < 5; i++) drive(gl[i], 1'b0, 8);
    check("t4_level", 32'(level), 32'd4);
    check("t4_ovf", 32'(ovf), 32'd1);
    check("t4_head0", 32'(rif.rd_nibble), 32'd0);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'd0);
    seg_in = ~gl[5];
    repeat (6) @(negedge clk);
    rif.rd_ready = 1'b1;
    @(negedge clk);
    rif.rd_ready = 1'b0;
    check("t4_full_level", 32'(level), 32'd4);
    check("t4_full_ovf", 32'(ovf), 32'd0);
    pop_expect("t4_e1", 6'h01);
    pop_expect("t4_e2", 6'h02);
    pop_expect("t4_e3", 6'h03);
    pop_expect("t4_e5", 6'h05);

    // 5: reset mid-filter with two entries queued; held glyph re-accepted after release
    drive(gl[6], 1'b0, 8);
    drive(gl[7], 1'b1, 8);
    check("t5_level_pre", 32'(level), 32'd2);
    drive(gl[8], 1'b0, 3);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(rif.rd_valid), 32'd0);
    check("t5_rst_level", 32'(level), 32'd0);
    check("t5_rst_nibble", 32'(rif.rd_nibble), 32'd0);
    check("t5_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("t5_re_valid", 32'(rif.rd_valid), 32'd1);
    check("t5_re_nibble", 32'(rif.rd_nibble), 32'd8);
    @(negedge clk);
    pop_expect("t5_pop", 6'h08);

    // 6: random glyphs and holds under a randomly stalling consumer
    for (int g = 0; g < 200; g++) begin
      int         k;
      int         hold;
      logic [6:0] lit;
      logic       dpl;
      k    = int'($urandom_range(0, 19));
      hold = int'($urandom_range(1, 9));
      dpl  = ($urandom_range(0, 3) == 0);
      if (k < 16)       lit = gl[k];
      else if (k == 16) lit = 7'h00;
      else              lit = 7'($urandom_range(1, 127));
      seg_in = ~lit;
      dp_in  = ~dpl;
      for (int c = 0; c < hold; c++) begin
        rif.rd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    rif.rd_ready = 1'b1;
    drive(7'h00, 1'b0, 20);
    rif.rd_ready = 1'b0;
    check("t6_drained", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
